// File: rtl/if_fetch_stage.sv
// RV32 instruction fetch stage: owns the fetch PC, issues imem requests,
// buffers responses in a 2-entry FIFO and drives the IF/ID register.
package if_fetch_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fb_ent_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        valid;
  } if_id_t;
endpackage

module if_fetch_stage
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        take_branch,
  input  logic [31:0] branch_target,
  output logic        proc2Imem_req,
  output logic [31:0] proc2Imem_addr,
  input  logic        Imem2proc_valid,
  input  logic [31:0] Imem2proc_data,
  output logic [31:0] if_id_IR,
  output logic [31:0] if_id_PC,
  output logic        if_id_valid_inst
);

  logic [31:0] fetch_pc;
  logic [31:0] pend_pc;
  logic        outstanding;
  logic        discard;
  fb_ent_t     fb [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  if_id_t      if_id_q;

  logic        pop;
  logic        resp_ok;
  logic        push;
  logic        req;
  logic [2:0]  need;

  assign pop     = ~stall & (count != 2'd0);
  assign resp_ok = Imem2proc_valid & ~discard;
  assign push    = resp_ok & ~take_branch;

  // Slots needed after this edge: buffered entries plus the
  // in-flight response that will land in the FIFO, minus a pop.
  assign need = {1'b0, count}
              + {2'b00, outstanding & ~discard}
              - {2'b00, pop};

  assign req = rst & ~take_branch
             & (~outstanding | Imem2proc_valid)
             & (need < 3'd2);

  always_ff @(posedge clk) begin
    if (push) fb[wr_ptr] <= '{pc: pend_pc, inst: Imem2proc_data};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      pend_pc     <= RESET_PC;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      if_id_q     <= '{pc: RESET_PC, ir: NOP_INST, valid: 1'b0};
    end else begin
      if (req) begin
        fetch_pc <= fetch_pc + 32'd4;
        pend_pc  <= fetch_pc;
      end else if (take_branch) begin
        fetch_pc <= branch_target;
      end

      outstanding <= req | (outstanding & ~Imem2proc_valid);

      // A redirect with a request still out poisons its response.
      if (take_branch)
        discard <= outstanding & ~Imem2proc_valid;
      else if (Imem2proc_valid)
        discard <= 1'b0;

      if (take_branch) begin
        count         <= 2'd0;
        rd_ptr        <= 1'b0;
        wr_ptr        <= 1'b0;
        if_id_q.valid <= 1'b0;
        if_id_q.ir    <= NOP_INST;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop) begin
          rd_ptr  <= ~rd_ptr;
          if_id_q <= '{pc: fb[rd_ptr].pc,
                       ir: fb[rd_ptr].inst,
                       valid: 1'b1};
        end else if (!stall) begin
          if_id_q.valid <= 1'b0;
          if_id_q.ir    <= NOP_INST;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  assign proc2Imem_req    = req;
  assign proc2Imem_addr   = fetch_pc;
  assign if_id_IR         = if_id_q.ir;
  assign if_id_PC         = if_id_q.pc;
  assign if_id_valid_inst = if_id_q.valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: variable-latency imem model plus an
// expected-instruction scoreboard refilled on reset and redirect.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        take_branch;
  logic [31:0] branch_target;
  logic        proc2Imem_req;
  logic [31:0] proc2Imem_addr;
  logic        Imem2proc_valid;
  logic [31:0] Imem2proc_data;
  logic [31:0] if_id_IR;
  logic [31:0] if_id_PC;
  logic        if_id_valid_inst;

  always #5 clk = ~clk;

  if_fetch_stage #(
    .RESET_PC(RST_PC),
    .NOP_INST(NOP)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .take_branch      (take_branch),
    .branch_target    (branch_target),
    .proc2Imem_req    (proc2Imem_req),
    .proc2Imem_addr   (proc2Imem_addr),
    .Imem2proc_valid  (Imem2proc_valid),
    .Imem2proc_data   (Imem2proc_data),
    .if_id_IR         (if_id_IR),
    .if_id_PC         (if_id_PC),
    .if_id_valid_inst (if_id_valid_inst)
  );

  typedef struct {
    int          lat;
    int          n;
    int          st_at;
    int          st_len;
    int          exp_cnt;
    logic [31:0] exp_last;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } ent_t;

  vec_t vecs [4];
  ent_t sb [$];

  int          n_chk = 0;
  int          n_fail = 0;
  int          lat = 1;
  bit          pend = 0;
  int          cnt = 0;
  logic [31:0] paddr = 32'h0;
  logic [31:0] exp_req = RST_PC;
  bit          rst_v = 0;
  bit          st_v = 0;
  bit          tb_v = 0;
  logic [31:0] tgt = 32'h0;
  int          delivered = 0;
  logic [31:0] last_pc = 32'h0;
  bit          got = 0;
  bit          req_s = 0;
  bit          vld_s = 0;
  logic [31:0] addr_s = 32'h0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5a00_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic refill(input logic [31:0] start);
    sb.delete();
    for (int i = 0; i < 64; i++)
      sb.push_back('{start + 32'(4 * i), memf(start + 32'(4 * i))});
  endtask

  task automatic tick();
    ent_t e;
    @(negedge clk);
    rst             = rst_v;
    stall           = st_v;
    take_branch     = tb_v;
    branch_target   = tgt;
    Imem2proc_valid = pend && (cnt == 1);
    Imem2proc_data  = Imem2proc_valid ? memf(paddr) : 32'h0;
    #1;
    if (!rst_v)
      chk("req_in_reset", 32'(proc2Imem_req), 32'h0);
    if (proc2Imem_req) begin
      chk("req_addr", proc2Imem_addr, exp_req);
      chk("one_in_flight", 32'(pend && !Imem2proc_valid), 32'h0);
    end
    req_s  = proc2Imem_req;
    addr_s = proc2Imem_addr;
    vld_s  = Imem2proc_valid;
    @(posedge clk);
    if (!rst_v) begin
      pend    = 0;
      exp_req = RST_PC;
      refill(RST_PC);
    end else begin
      if (vld_s) pend = 0;
      else if (pend) cnt--;
      if (req_s) begin
        pend    = 1;
        cnt     = lat;
        paddr   = addr_s;
        exp_req = exp_req + 32'd4;
      end
      if (tb_v) begin
        exp_req = tgt;
        refill(tgt);
      end
    end
    #1;
    got = 0;
    if (!rst_v) begin
      chk("rst_valid", 32'(if_id_valid_inst), 32'h0);
      chk("rst_ir", if_id_IR, NOP);
      chk("rst_pc", if_id_PC, RST_PC);
    end else if (tb_v) begin
      chk("redirect_valid", 32'(if_id_valid_inst), 32'h0);
      chk("redirect_ir", if_id_IR, NOP);
    end else if (!st_v) begin
      if (if_id_valid_inst) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'h1, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("if_id_PC", if_id_PC, e.pc);
          chk("if_id_IR", if_id_IR, e.ir);
        end
        got = 1;
        delivered++;
        last_pc = if_id_PC;
      end else begin
        chk("idle_ir", if_id_IR, NOP);
      end
    end
  endtask

  task automatic do_reset(input int l);
    lat   = l;
    rst_v = 0;
    st_v  = 0;
    tb_v  = 0;
    repeat (2) tick();
    rst_v     = 1;
    delivered = 0;
  endtask

  task automatic wait_valid(input string nm, output int k);
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      tick();
      if (got) k = i;
    end
    if (k == 0) chk(nm, 32'h0, 32'h1);
  endtask

  initial begin
    int k;
    rst             = 1'b0;
    stall           = 1'b0;
    take_branch     = 1'b0;
    branch_target   = 32'h0;
    Imem2proc_valid = 1'b0;
    Imem2proc_data  = 32'h0;
    refill(RST_PC);

    vecs[0] = '{1, 20, 0, 0, 18, 32'h44};
    vecs[1] = '{2, 20, 0, 0, 9,  32'h20};
    vecs[2] = '{3, 20, 0, 0, 6,  32'h14};
    vecs[3] = '{1, 20, 8, 5, 13, 32'h30};

    for (int v = 0; v < 4; v++) begin
      do_reset(vecs[v].lat);
      for (int e = 1; e <= vecs[v].n; e++) begin
        st_v = (e >= vecs[v].st_at) &&
               (e < vecs[v].st_at + vecs[v].st_len);
        tick();
        if (st_v && e == vecs[v].st_at + vecs[v].st_len - 1)
          chk("stall_req_drop", 32'(req_s), 32'h0);
      end
      st_v = 0;
      chk("vec_count", 32'(delivered), 32'(vecs[v].exp_cnt));
      chk("vec_last_pc", last_pc, vecs[v].exp_last);
    end

    // Redirect to 0x100 while the 0x20 fetch is in flight, L=3.
    do_reset(3);
    repeat (25) tick();
    tgt  = 32'h100;
    tb_v = 1;
    tick();
    tb_v = 0;
    wait_valid("redir_timeout", k);
    if (k != 0) chk("redir_pc", last_pc, 32'h100);
    repeat (8) tick();

    // Redirect with stall on the same edge as a response, L=1.
    do_reset(1);
    repeat (10) tick();
    tgt  = 32'h200;
    st_v = 1;
    tb_v = 1;
    tick();
    st_v = 0;
    tb_v = 0;
    wait_valid("redir_stall_timeout", k);
    chk("redir_stall_latency", 32'(k), 32'd3);
    chk("redir_stall_pc", last_pc, 32'h200);
    repeat (4) tick();

    // One-cycle reset with a full FIFO, then restart.
    do_reset(1);
    repeat (8) tick();
    st_v = 1;
    repeat (3) tick();
    st_v  = 0;
    rst_v = 0;
    tick();
    rst_v = 1;
    wait_valid("restart_timeout", k);
    chk("restart_latency", 32'(k), 32'd3);
    chk("restart_pc", last_pc, RST_PC);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
